uart_rx_cfg: RTL

//  Parametrised UART receiver: configurable data width, parity mode and stop-bit count.

---
 rtl/uart_rx_cfg.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Purpose    : parametrised UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits)
//              with start-bit validation and parity / framing error reporting.
// Latency    : po_flag rises one sys_clk after the mid-bit decision of the final stop bit.
// Backpressure: none; the consumer must take po_data on the po_flag cycle (values hold until the next flag).
// Ports      : sys_clk, sys_rst (sync, active-high), rx (async serial, idle high)
//              po_data[DATA_BITS], po_flag (1-cycle strobe), po_parity_err, po_frame_err, busy
// Option     : define UART_RX_MAJORITY_EN for a 2-of-3 vote over the last three mid-bit samples.
module uart_rx_cfg #(
    parameter int UART_BPS  = 9600,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 po_parity_err,
    output logic                 po_frame_err,
    output logic                 busy
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam int CW           = $clog2(BAUD_CNT_MAX);
    localparam int BW           = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_hist;
    logic [CW-1:0]        r_baud;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 w_start_edge;
    logic                 w_decide;
    logic                 w_bit;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_par;

    assign w_start_edge = (r_state == S_IDLE) && !r_sync2 && r_hist;
    assign w_decide     = (r_baud == CW'(HALF));
    assign w_last_data  = (r_bit == BW'(DATA_BITS - 1));
    assign w_last_stop  = (r_bit == BW'(STOP_BITS - 1));
    assign w_par        = ^r_shift;
    assign busy         = (r_state != S_IDLE);

`ifdef UART_RX_MAJORITY_EN
    // Two earlier samples are held; the third is the live synchroniser output
    // at HALF, so the decision lands on the same cycle as the single-sample build.
    logic r_v0;
    logic r_v1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_v0 <= 1'b1;
            r_v1 <= 1'b1;
        end else begin
            if (r_baud == CW'(HALF - 2)) r_v0 <= r_sync2;
            if (r_baud == CW'(HALF - 1)) r_v1 <= r_sync2;
        end
    end

    assign w_bit = (r_v0 & r_v1) | (r_v0 & r_sync2) | (r_v1 & r_sync2);
`else
    assign w_bit = r_sync2;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_edge) w_next = S_START;
            S_START:  if (w_decide) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && w_last_data) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_next = S_STOP;
            S_STOP:   if (w_decide && w_last_stop) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_hist        <= 1'b1;
            r_baud        <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_par_err     <= 1'b0;
            r_frm_err     <= 1'b0;
            po_data       <= '0;
            po_flag       <= 1'b0;
            po_parity_err <= 1'b0;
            po_frame_err  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            po_flag <= 1'b0;

            // Held at zero in IDLE, so a frame always enters START with a cleared counter.
            if (r_state == S_IDLE)                         r_baud <= '0;
            else if (r_baud == CW'(BAUD_CNT_MAX - 1))      r_baud <= '0;
            else                                           r_baud <= r_baud + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_bit     <= '0;
                        r_par_err <= 1'b0;
                        r_frm_err <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit   <= w_last_data ? '0 : r_bit + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_err <= (PARITY == 1) ? ~(w_par ^ w_bit) : (w_par ^ w_bit);
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        if (!w_bit) r_frm_err <= 1'b1;
                        if (w_last_stop) begin
                            r_bit         <= '0;
                            po_flag       <= 1'b1;
                            po_data       <= r_shift;
                            po_parity_err <= r_par_err;
                            po_frame_err  <= r_frm_err | ~w_bit;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
